// File: rtl/bcd_down_counter.sv
// bcd_down_counter: loadable N-digit BCD countdown timer with one-cycle expiry pulse
// and optional auto-reload from the last valid preset.
module bcd_down_counter #(
    parameter int DIGITS      = 4,
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_ce,
    input  logic                  i_load,
    input  logic [4*DIGITS-1:0]   i_load_val,
    input  logic                  i_start,
    input  logic                  i_stop,
    output logic [4*DIGITS-1:0]   o_q,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_load_err
);
    localparam int W = 4 * DIGITS;

    typedef enum logic {IDLE, RUN} state_t;

    state_t              r_state;
    logic [W-1:0]        r_q;
    logic [W-1:0]        r_reload;
    logic                r_done;
    logic                r_load_err;

    logic [W-1:0]        w_dec;
    logic [DIGITS-1:0]   w_borrow;
    logic [DIGITS-1:0]   w_digit_ok;
    logic                w_load_ok;
    logic                w_zero;
    logic                w_dec_zero;

    // w_borrow[d] is the borrow into digit d; digit 0 always receives the -1
    assign w_borrow[0] = 1'b1;

    for (genvar d = 0; d < DIGITS; d++) begin : g_digit
        logic [3:0] w_nib;
        assign w_nib                = r_q[4*d +: 4];
        assign w_dec[4*d +: 4]      = w_borrow[d] ? ((w_nib == 4'd0) ? 4'd9 : w_nib - 4'd1) : w_nib;
        assign w_digit_ok[d]        = i_load_val[4*d +: 4] <= 4'd9;
        if (d < DIGITS - 1) begin : g_borrow
            assign w_borrow[d+1] = w_borrow[d] && (w_nib == 4'd0);
        end
    end

    assign w_load_ok  = &w_digit_ok;
    assign w_zero     = (r_q == '0);
    assign w_dec_zero = (w_dec == '0);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state    <= IDLE;
            r_q        <= '0;
            r_reload   <= '0;
            r_done     <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_load_err <= 1'b0;
            if (i_load) begin
                if (w_load_ok) begin
                    r_q      <= i_load_val;
                    r_reload <= i_load_val;
                    r_state  <= IDLE;
                end else begin
                    r_load_err <= 1'b1;
                end
            end else if (i_stop) begin
                r_state <= IDLE;
            end else if (i_start && r_state == IDLE) begin
                if (!w_zero) r_state <= RUN;
            end else if (r_state == RUN && i_ce) begin
                // q==0 while running only occurs after an auto-reload expiry
                if (w_zero) begin
                    if (r_reload == '0) r_state <= IDLE;
                    else r_q <= r_reload;
                end else begin
                    r_q <= w_dec;
                    if (w_dec_zero) begin
                        r_done <= 1'b1;
                        if (!AUTO_RELOAD) r_state <= IDLE;
                    end
                end
            end
        end
    end

    assign o_q        = r_q;
    assign o_busy     = (r_state == RUN);
    assign o_done     = r_done;
    assign o_load_err = r_load_err;
endmodule

// File: doc/bcd_down_counter.md
Name: bcd_down_counter

Overview:
Loadable N-digit BCD countdown timer, the down-counting counterpart of the team's saturating BCD up-counter.
- Accepts a BCD preset and decrements it one count per enabled tick until it reaches zero.
- Signals expiry with a one-cycle done pulse.
- Optionally auto-reloads for periodic operation.
- Sits between a control register block (load/start/stop) and a display or sequencer that consumes q and done.

Parameters:
DIGITS, 4, number of BCD digits; q width = 4*DIGITS.
AUTO_RELOAD, 0, 1 = on expiry stay in RUN and reload from the last valid preset on the next tick; 0 = return to IDLE.

Ports:
clk  input  1  rising-edge clock, sole clock domain
rst_n  input  1  synchronous active-low reset
ce  input  1  count enable tick; one decrement per cycle with ce=1 in RUN
load  input  1  load request; samples load_val
load_val  input  4*DIGITS  BCD preset, digit 0 in bits [3:0]
start  input  1  start/resume request
stop  input  1  pause request
q  output  4*DIGITS  current BCD count, registered
busy  output  1  high while in RUN, registered
done  output  1  one-cycle expiry pulse, registered
load_err  output  1  one-cycle pulse: load rejected because a digit > 9

Behaviour:
- Reset: applied only on a clk edge with rst_n=0; overrides every other input.
  - q=0, reload register=0, state IDLE, busy=0, done=0, load_err=0.
  - Reset mid-run aborts immediately; no done pulse.
- States: IDLE, RUN. busy = (state==RUN).
- Per-cycle input priority: rst_n > load > stop > start > ce.
- load:
  - Valid (every digit <= 9): q <= load_val, reload register <= load_val, state <= IDLE (aborts a run), load_err=0.
  - Invalid: q, reload register and state unchanged; load_err=1 for exactly one cycle.
  - ce is ignored in any cycle with load=1.
- stop: in RUN -> IDLE, q held, no decrement that cycle. In IDLE it has no effect.
- start:
  - IDLE with q != 0 -> RUN on the next edge; no decrement that cycle.
  - IDLE with q == 0 is ignored.
  - In RUN it has no effect; ce is still honoured that cycle.
- Decrement (RUN, ce=1, no higher-priority input):
  - BCD subtract 1, ripple-borrow: a digit of 0 becomes 9 and borrows from the next digit; a nonzero digit decrements and stops the borrow.
  - Result always valid BCD; 1000 -> 0999.
- Expiry: the decrement that yields q == 0 asserts done=1 on the same edge, so done is high in the first cycle q reads 0.
  - AUTO_RELOAD=0: state -> IDLE on that edge (busy falls with done rising).
  - AUTO_RELOAD=1: state stays RUN. The next ce with q == 0 loads the reload register instead of decrementing, so the period is preset+1 ticks.
  - If the reload register is 0 on that load: state -> IDLE, no further done.
- done is never high for two consecutive cycles. It is 0 in every cycle not following an expiry edge.
- q never underflows: decrement is never applied when q == 0 (AUTO_RELOAD=0 is already IDLE there).
- Inputs are synchronous to clk; no internal synchronisers.

Test Plan:
- Reset, load 0x0012, start, ce=1 continuously -> busy=1. q sequence 0012, 0011, 0010, 0009 … 0001, 0000. done=1 only in the 0000 cycle, busy=0 in the same cycle.
- Load 0x1000, start, one ce pulse -> q=0x0999 (full borrow chain). Load 0x9999 -> nine ce pulses -> q=0x9990.
- Load 0x00A5 while q=0x0042 -> q stays 0x0042, load_err high exactly one cycle. Load 0x0000 then start -> busy stays 0.
- Load 0x0005, start, two ticks (q=0x0003), stop together with ce -> q=0x0003, busy=0. Idle ticks leave q unchanged. start -> resumes, done after three more ticks.
- Run from 0x0050 and assert rst_n=0 for one cycle at q=0x0031 -> q=0, busy=0, no done pulse. load in RUN -> new value, state IDLE.
- AUTO_RELOAD=1: load 0x0003, start, ce continuous -> q 3, 2, 1, 0 (done), 3, 2, 1, 0 (done). busy held high throughout. done pulses every 4 ticks.
